tl_ul_mem_responder: RTL and testbench
======================================

// Module: tl_ul_mem_responder
// PURPOSE
//  TileLink-UL manager (responder) for one 32-bit lane; the memory end of the core's dmem_N/imem_0 ports.
//  Accepts Get/PutFullData/PutPartialData on channel A and returns AccessAckData/AccessAck on channel D.
//  Backed by a word SRAM, with a response FIFO that absorbs d_ready backpressure.
//  The top instantiates one per dmem lane plus one for imem, as the memory model for tile-level sims.
// PARAMETERS
//  BASE_ADDR    32'hC000_0000  byte address of word 0
//  DEPTH_WORDS  1024           SRAM words (power of 2); window = DEPTH_WORDS*4 bytes
//  SRC_W        10             source field width
//  RSP_DEPTH    4              response FIFO entries (>=2)
//  SINK_ID      3'd0           constant driven on d_bits_sink
// PORTS
//  clock           in   1      clock
//  reset           in   1      asynchronous, active-high reset
//  a_valid         in   1      A request valid
//  a_ready         out  1      A request ready
//  a_bits_opcode   in   3      0 PutFull, 1 PutPartial, 4 Get
//  a_bits_param    in   3      ignored
//  a_bits_size     in   4      log2 bytes; echoed on D
//  a_bits_source   in   SRC_W  echoed on D
//  a_bits_address  in   32     byte address; [1:0] ignored
//  a_bits_mask     in   4      byte enables for Put
//  a_bits_data     in   32     Put data
//  a_bits_corrupt  in   1      Put data poisoned
//  d_valid         out  1      D response valid
//  d_ready         in   1      D response ready
//  d_bits_opcode   out  3      0 AccessAck, 1 AccessAckData
//  d_bits_param    out  2      always 0
//  d_bits_size     out  4      = request size
//  d_bits_source   out  SRC_W  = request source
//  d_bits_sink     out  3      SINK_ID
//  d_bits_denied   out  1      request rejected
//  d_bits_data     out  32     read data; 0 for AccessAck or when denied
//  d_bits_corrupt  out  1      = denied for Get, 0 otherwise
// BEHAVIOUR
//  - Reset (async assert): a_ready=0, d_valid=0, all d_bits=0; FIFO, S1 stage and credit counter are cleared.
//  - Reset mid-operation drops all in-flight requests. SRAM contents are preserved, not cleared.
//  - First cycle after deassert: a_ready=1.
//  - Credits: credit = RSP_DEPTH - (FIFO count + S1 valid); a_ready = (credit != 0).
//    A request is accepted only when a space is guaranteed; d_ready never stalls the pipe.
//  - Accept: a_valid&&a_ready. A Put writes at the accept edge, per mask byte.
//    A Get issues a synchronous read at the accept edge. Metadata is registered into S1.
//  - S1 enqueues into the FIFO the next edge.
//    Minimum latency: accepted in cycle N -> d_valid in cycle N+2.
//    One request per cycle sustained while d_ready=1.
//  - Response pops on d_valid&&d_ready. d_bits are stable while d_valid&&!d_ready.
//  - Simultaneous push and pop on a full FIFO is legal; the count is unchanged.
//  - Back-to-back Put then Get to the same word: the Get returns the new data (write precedes the next read edge).
//  - Denied (no write; d_data=0; d_denied=1), any of:
//    - address outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4)
//    - size > 2
//    - opcode not in {0,1,4}
//    - Put with a_bits_corrupt=1
//  - Denied opcode mapping: a Get still returns AccessAckData; an illegal opcode returns AccessAck.
//  - PutFull with mask != 4'hF writes per mask; it is not denied.
//  - Index = (address - BASE_ADDR)>>2, truncated to log2(DEPTH_WORDS) bits after the range check.
// CONFIGURATION
//  TL_MEM_RANDSTALL_EN defined:
//    - 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances every cycle.
//    - a_ready is additionally forced low when lfsr[1:0]==2'b00.
//    - d_valid is withheld (FIFO not popped) when lfsr[3:2]==2'b00.
//    - Ordering and data are unaffected.
//  TL_MEM_RANDSTALL_EN undefined: no LFSR; a_ready and d_valid as above.
// STRUCTURE
//  - Package tl_ul_pkg:
//    - tl_a_op_e {PUT_FULL=0, PUT_PARTIAL=1, GET=4}
//    - tl_d_op_e {ACCESS_ACK=0, ACCESS_ACK_DATA=1}
//    - tl_d_t struct (opcode, size, source, denied, data, corrupt)
//    - TL_DATA_W=32, TL_MASK_W=4
//  - Sub-module tl_mem_rsp_fifo: synchronous FIFO of tl_d_t, RSP_DEPTH entries, count output.
//  - SRAM array, S1 stage, credit logic and LFSR live in the top.
// TESTING
//  1. Reset released; PutFull addr C000_0010 data DEADBEEF src 5, then Get same addr src 6
//     -> D: AccessAck src5, then AccessAckData DEADBEEF src6, no denied.
//  2. PutPartial mask 4'b0011 data 0000_1234 over word AABBCCDD -> a later Get returns AABB1234.
//  3. d_ready=0, 8 Gets offered -> exactly RSP_DEPTH accepted, then a_ready=0;
//     release d_ready -> responses in order, a_ready reasserts.
//  4. Get at BASE_ADDR+DEPTH_WORDS*4 -> AccessAckData denied=1 corrupt=1 data=0;
//     opcode 3 -> AccessAck denied=1; memory unchanged.
//  5. Stream 100 Gets with d_ready=1 -> first d_valid 2 cycles after accept, then 1 response/cycle.
//  6. Reset asserted with 3 responses queued
//     -> d_valid=0 immediately, no stale responses after release; SRAM data intact.
//  Also run 1-6 with TL_MEM_RANDSTALL_EN defined; the scoreboard checks order and data.

Source files
------------

// File: rtl/tl_ul_mem_responder_pkg.sv
// Shared TileLink-UL types for the memory responder: channel opcodes and the D-channel beat.
package tl_ul_pkg;

    localparam int unsigned TL_DATA_W    = 32;
    localparam int unsigned TL_MASK_W    = 4;
    localparam int unsigned TL_SRC_MAX_W = 16;

    typedef enum logic [2:0] {
        PUT_FULL    = 3'd0,
        PUT_PARTIAL = 3'd1,
        GET         = 3'd4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        ACCESS_ACK      = 3'd0,
        ACCESS_ACK_DATA = 3'd1
    } tl_d_op_e;

    // Source is carried at its widest supported width; the top trims it to SRC_W.
    typedef struct packed {
        tl_d_op_e                opcode;
        logic [3:0]              size;
        logic [TL_SRC_MAX_W-1:0] source;
        logic                    denied;
        logic [TL_DATA_W-1:0]    data;
        logic                    corrupt;
    } tl_d_t;

endpackage

// File: rtl/tl_ul_mem_responder_if.sv
// TileLink-UL A/D channel bundle for one 32-bit lane; master = requester, slave = memory.
interface tl_ul_mem_responder_if
    import tl_ul_pkg::*;
#(
    parameter int unsigned SRC_W = 10
);
    logic                 a_valid;
    logic                 a_ready;
    logic [2:0]           a_bits_opcode;
    logic [2:0]           a_bits_param;
    logic [3:0]           a_bits_size;
    logic [SRC_W-1:0]     a_bits_source;
    logic [31:0]          a_bits_address;
    logic [TL_MASK_W-1:0] a_bits_mask;
    logic [TL_DATA_W-1:0] a_bits_data;
    logic                 a_bits_corrupt;

    logic                 d_valid;
    logic                 d_ready;
    logic [2:0]           d_bits_opcode;
    logic [1:0]           d_bits_param;
    logic [3:0]           d_bits_size;
    logic [SRC_W-1:0]     d_bits_source;
    logic [2:0]           d_bits_sink;
    logic                 d_bits_denied;
    logic [TL_DATA_W-1:0] d_bits_data;
    logic                 d_bits_corrupt;

    modport master (
        output a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
               a_bits_address, a_bits_mask, a_bits_data, a_bits_corrupt, d_ready,
        input  a_ready, d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_source,
               d_bits_sink, d_bits_denied, d_bits_data, d_bits_corrupt
    );

    modport slave (
        input  a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
               a_bits_address, a_bits_mask, a_bits_data, a_bits_corrupt, d_ready,
        output a_ready, d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_source,
               d_bits_sink, d_bits_denied, d_bits_data, d_bits_corrupt
    );
endinterface

// File: rtl/tl_ul_mem_responder_fifo.sv
// Response FIFO (module tl_mem_rsp_fifo) holding D-channel beats; push on a full FIFO is allowed with a pop.
module tl_mem_rsp_fifo
    import tl_ul_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  tl_d_t            data_i,
    input  logic             pop_i,
    output tl_d_t            data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    tl_d_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_d  = do_push ? ptr_inc(wr_q) : wr_q;
        rd_d  = do_pop ? ptr_inc(rd_q) : rd_q;
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/tl_ul_mem_responder.sv
// TileLink-UL memory responder: word SRAM, S1 metadata stage, credit-gated A, FIFO-buffered D.
// Optional TL_MEM_RANDSTALL_EN inserts LFSR-driven stalls on a_ready and d_valid.
module tl_ul_mem_responder
    import tl_ul_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'hC000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned SRC_W       = 10,
    parameter int unsigned RSP_DEPTH   = 4,
    parameter logic [2:0]  SINK_ID     = 3'd0
) (
    input logic                  clock,
    input logic                  reset,
    tl_ul_mem_responder_if.slave tl
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

    logic [TL_DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [TL_DATA_W-1:0] rdata_q;

    logic [31:0]      offset;
    logic [IDX_W-1:0] idx;
    logic             accept, is_get, is_put, in_range, denied;

    logic             s1_valid_q, s1_valid_d, s1_get_q, s1_get_d, s1_denied_q, s1_denied_d;
    tl_d_op_e         s1_op_q, s1_op_d;
    logic [3:0]       s1_size_q, s1_size_d;
    logic [SRC_W-1:0] s1_source_q, s1_source_d;

    tl_d_t            push_data, fifo_head, d_out;
    logic             fifo_empty, fifo_full, d_vld, a_stall, d_stall;
    logic [CNT_W-1:0] fifo_cnt, used;

    assign offset   = tl.a_bits_address - BASE_ADDR;
    assign idx      = offset[IDX_W+1:2];
    assign in_range = offset[31:2] < 30'(DEPTH_WORDS);
    assign is_get   = (tl.a_bits_opcode == GET);
    assign is_put   = (tl.a_bits_opcode == PUT_FULL) || (tl.a_bits_opcode == PUT_PARTIAL);
    assign denied   = !in_range || (tl.a_bits_size > 4'd2) || !(is_get || is_put)
                      || (is_put && tl.a_bits_corrupt);

`ifdef TL_MEM_RANDSTALL_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) lfsr_q <= 16'hACE1;
        else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    assign a_stall = (lfsr_q[1:0] == 2'b00);
    assign d_stall = (lfsr_q[3:2] == 2'b00);
`else
    assign a_stall = 1'b0;
    assign d_stall = 1'b0;
`endif

    // Credits count both queued beats and the one in S1, so an accept always has a FIFO slot.
    assign used       = fifo_cnt + CNT_W'(s1_valid_q);
    assign tl.a_ready = !reset && (used != CNT_W'(RSP_DEPTH)) && !a_stall;
    assign accept     = tl.a_valid && tl.a_ready;

    always_ff @(posedge clock) begin
        if (accept && is_put && !denied) begin
            for (int unsigned b = 0; b < TL_MASK_W; b++) begin
                if (tl.a_bits_mask[b]) mem_q[idx][8*b +: 8] <= tl.a_bits_data[8*b +: 8];
            end
        end
        if (accept && is_get) rdata_q <= mem_q[idx];
    end

    always_comb begin
        s1_valid_d  = accept;
        s1_get_d    = is_get;
        s1_denied_d = denied;
        s1_op_d     = is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
        s1_size_d   = tl.a_bits_size;
        s1_source_d = tl.a_bits_source;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_get_q    <= 1'b0;
            s1_denied_q <= 1'b0;
            s1_op_q     <= ACCESS_ACK;
            s1_size_q   <= '0;
            s1_source_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_get_q    <= s1_get_d;
            s1_denied_q <= s1_denied_d;
            s1_op_q     <= s1_op_d;
            s1_size_q   <= s1_size_d;
            s1_source_q <= s1_source_d;
        end
    end

    always_comb begin
        push_data         = '0;
        push_data.opcode  = s1_op_q;
        push_data.size    = s1_size_q;
        push_data.source  = TL_SRC_MAX_W'(s1_source_q);
        push_data.denied  = s1_denied_q;
        push_data.data    = (s1_get_q && !s1_denied_q) ? rdata_q : '0;
        push_data.corrupt = s1_get_q && s1_denied_q;
    end

    tl_mem_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .CNT_W (CNT_W)
    ) u_rsp_fifo (
        .clock_i (clock),
        .reset_i (reset),
        .push_i  (s1_valid_q),
        .data_i  (push_data),
        .pop_i   (d_vld && tl.d_ready),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_cnt)
    );

    // FIFO storage is not reset, so the head is masked to keep d_bits zero while idle.
    assign d_vld             = !fifo_empty && !d_stall;
    assign d_out             = d_vld ? fifo_head : '0;
    assign tl.d_valid        = d_vld;
    assign tl.d_bits_opcode  = d_out.opcode;
    assign tl.d_bits_param   = '0;
    assign tl.d_bits_size    = d_out.size;
    assign tl.d_bits_source  = d_out.source[SRC_W-1:0];
    assign tl.d_bits_sink    = SINK_ID;
    assign tl.d_bits_denied  = d_out.denied;
    assign tl.d_bits_data    = d_out.data;
    assign tl.d_bits_corrupt = d_out.corrupt;

    logic unused_ok;
    assign unused_ok = ^{tl.a_bits_param, offset[1:0], d_out.source, fifo_full};

endmodule

// File: tb/tb_tl_ul_mem_responder.sv
// Scoreboard bench: directed A-channel requests push expected D beats; a negedge monitor pops and compares.
module tb_tl_ul_mem_responder;
    import tl_ul_pkg::*;

    localparam logic [31:0] BASE = 32'hC000_0000;

    typedef struct {
        logic [2:0]  op;
        logic [9:0]  src;
        logic [3:0]  size;
        logic        den;
        logic [31:0] data;
        logic        corr;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;
    int          cyc = 0;
    int          last_acc_cyc = 0;
    exp_t        sb_q[$];
    int          pop_cyc_q[$];
    exp_t        mon_e;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    tl_ul_mem_responder_if #(.SRC_W(10)) tl();

    tl_ul_mem_responder #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (1024),
        .SRC_W       (10),
        .RSP_DEPTH   (4),
        .SINK_ID     (3'd0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .tl    (tl.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic exp_t mk(input logic [2:0] op, input logic [9:0] src, input logic [3:0] size,
                                input logic den, input logic [31:0] data, input logic corr);
        exp_t e;
        e.op = op; e.src = src; e.size = size; e.den = den; e.data = data; e.corr = corr;
        return e;
    endfunction

    always @(negedge clock) begin
        if (!reset && tl.d_valid && tl.d_ready) begin
            pop_cyc_q.push_back(cyc);
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", {22'd0, tl.d_bits_source}, 32'hFFFF_FFFF);
            end else begin
                mon_e = sb_q.pop_front();
                chk("d_opcode", {29'd0, tl.d_bits_opcode}, {29'd0, mon_e.op});
                chk("d_source", {22'd0, tl.d_bits_source}, {22'd0, mon_e.src});
                chk("d_size", {28'd0, tl.d_bits_size}, {28'd0, mon_e.size});
                chk("d_denied", {31'd0, tl.d_bits_denied}, {31'd0, mon_e.den});
                chk("d_data", tl.d_bits_data, mon_e.data);
                chk("d_corrupt", {31'd0, tl.d_bits_corrupt}, {31'd0, mon_e.corr});
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] wdata, input logic corr, input logic [9:0] src,
                        input logic [3:0] size, input exp_t e);
        bit ok = 1'b0;
        tl.a_valid = 1'b1; tl.a_bits_opcode = op; tl.a_bits_address = addr;
        tl.a_bits_mask = mask; tl.a_bits_data = wdata; tl.a_bits_corrupt = corr;
        tl.a_bits_source = src; tl.a_bits_size = size;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            if (tl.a_ready) begin
                last_acc_cyc = cyc;
                ok = 1'b1;
            end
            @(posedge clock);
        end
        if (ok) sb_q.push_back(e);
        else chk("a_ready_timeout", 32'd0, 32'd1);
        #1 tl.a_valid = 1'b0;
    endtask

    task automatic tl_get(input logic [31:0] addr, input logic [9:0] src, input logic [31:0] edata);
        send(3'd4, addr, 4'hF, 32'd0, 1'b0, src, 4'd2, mk(3'd1, src, 4'd2, 1'b0, edata, 1'b0));
    endtask

    task automatic tl_put(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                          input logic [31:0] wdata, input logic [9:0] src);
        send(op, addr, mask, wdata, 1'b0, src, 4'd2, mk(3'd0, src, 4'd2, 1'b0, 32'd0, 1'b0));
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 500 && sb_q.size() != 0; i++) begin
            @(posedge clock);
            #1;
        end
        chk(name, sb_q.size(), 32'd0);
    endtask

    task automatic wait_a_ready(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            seen = tl.a_ready;
        end
        chk(name, {31'd0, seen}, 32'd1);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int acc;
        int first_acc;
        bit rdy;
        tl.a_valid = 1'b0; tl.a_bits_opcode = '0; tl.a_bits_param = '0; tl.a_bits_size = '0;
        tl.a_bits_source = '0; tl.a_bits_address = '0; tl.a_bits_mask = '0; tl.a_bits_data = '0;
        tl.a_bits_corrupt = 1'b0; tl.d_ready = 1'b1;

        #2;
        chk("rst_a_ready", {31'd0, tl.a_ready}, 32'd0);
        chk("rst_d_valid", {31'd0, tl.d_valid}, 32'd0);
        chk("rst_d_data", tl.d_bits_data, 32'd0);
        chk("rst_d_source", {22'd0, tl.d_bits_source}, 32'd0);
        @(posedge clock); @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk("a_ready_after_rst", {31'd0, tl.a_ready}, 32'd1);
        @(posedge clock); #1;

        // 1: PutFull then Get same word back-to-back
        tl_put(3'd0, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF, 10'd5);
        tl_get(BASE + 32'h10, 10'd6, 32'hDEAD_BEEF);
        // 2: partial write merge, and PutFull honouring a sparse mask
        tl_put(3'd0, BASE + 32'h20, 4'hF, 32'hAABB_CCDD, 10'd1);
        tl_put(3'd1, BASE + 32'h20, 4'b0011, 32'h0000_1234, 10'd2);
        tl_get(BASE + 32'h20, 10'd3, 32'hAABB_1234);
        tl_put(3'd0, BASE + 32'h20, 4'b1100, 32'h9988_7766, 10'd4);
        tl_get(BASE + 32'h20, 10'd7, 32'h9988_1234);
        tl_put(3'd0, BASE + 32'hFFC, 4'hF, 32'h1122_3344, 10'd8);
        tl_get(BASE + 32'hFFC, 10'd9, 32'h1122_3344);
        drain("t1_t2_drain");

        // 3: backpressure fills exactly RSP_DEPTH credits
        tl.d_ready = 1'b0;
        acc = 0;
        tl.a_valid = 1'b1; tl.a_bits_opcode = 3'd4; tl.a_bits_address = BASE + 32'h10;
        tl.a_bits_size = 4'd2; tl.a_bits_mask = 4'hF; tl.a_bits_corrupt = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tl.a_bits_source = 10'(20 + acc);
            @(negedge clock);
            rdy = tl.a_ready;
            @(posedge clock);
            if (rdy) begin
                sb_q.push_back(mk(3'd1, 10'(20 + acc), 4'd2, 1'b0, 32'hDEAD_BEEF, 1'b0));
                acc++;
            end
            #1;
        end
        tl.a_valid = 1'b0;
        chk("t3_accepted", acc, 32'd4);
        @(negedge clock);
        chk("t3_a_ready_low", {31'd0, tl.a_ready}, 32'd0);
        @(posedge clock); #1 tl.d_ready = 1'b1;
        drain("t3_drain");
        wait_a_ready("t3_a_ready_back");

        // 4: denied requests and memory left intact
        send(3'd4, BASE + 32'h1000, 4'hF, 32'd0, 1'b0, 10'd30, 4'd2,
             mk(3'd1, 10'd30, 4'd2, 1'b1, 32'd0, 1'b1));
        send(3'd4, BASE - 32'd4, 4'hF, 32'd0, 1'b0, 10'd31, 4'd2,
             mk(3'd1, 10'd31, 4'd2, 1'b1, 32'd0, 1'b1));
        send(3'd3, BASE + 32'h10, 4'hF, 32'h1234_5678, 1'b0, 10'd32, 4'd2,
             mk(3'd0, 10'd32, 4'd2, 1'b1, 32'd0, 1'b0));
        send(3'd4, BASE + 32'h10, 4'hF, 32'd0, 1'b0, 10'd33, 4'd3,
             mk(3'd1, 10'd33, 4'd3, 1'b1, 32'd0, 1'b1));
        send(3'd0, BASE + 32'h20, 4'hF, 32'h0BAD_0BAD, 1'b1, 10'd34, 4'd2,
             mk(3'd0, 10'd34, 4'd2, 1'b1, 32'd0, 1'b0));
        tl_get(BASE + 32'h10, 10'd35, 32'hDEAD_BEEF);
        tl_get(BASE + 32'h20, 10'd36, 32'h9988_1234);
        drain("t4_drain");

        // 5: streaming Gets
        pop_cyc_q.delete();
        first_acc = 0;
        for (int i = 0; i < 100; i++) begin
            if (i % 2 == 0) tl_get(BASE + 32'h10, 10'(i), 32'hDEAD_BEEF);
            else            tl_get(BASE + 32'h20, 10'(i), 32'h9988_1234);
            if (i == 0) first_acc = last_acc_cyc;
        end
        drain("t5_drain");
        chk("t5_rsp_count", pop_cyc_q.size(), 32'd100);
`ifndef TL_MEM_RANDSTALL_EN
        if (pop_cyc_q.size() == 100) begin
            chk("t5_first_latency", pop_cyc_q[0] - first_acc, 32'd2);
            chk("t5_stream_span", pop_cyc_q[99] - pop_cyc_q[0], 32'd99);
        end
`endif

        // 6: reset with responses queued
        tl.d_ready = 1'b0;
        tl_get(BASE + 32'h10, 10'd40, 32'hDEAD_BEEF);
        tl_get(BASE + 32'h10, 10'd41, 32'hDEAD_BEEF);
        tl_get(BASE + 32'h10, 10'd42, 32'hDEAD_BEEF);
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("t6_d_valid_in_rst", {31'd0, tl.d_valid}, 32'd0);
        chk("t6_a_ready_in_rst", {31'd0, tl.a_ready}, 32'd0);
        chk("t6_d_data_in_rst", tl.d_bits_data, 32'd0);
        sb_q.delete();
        @(posedge clock); @(posedge clock); #1 reset = 1'b0;
        tl.d_ready = 1'b1;
        @(negedge clock);
        chk("t6_a_ready_after", {31'd0, tl.a_ready}, 32'd1);
        repeat (10) @(posedge clock);
        #1;
        tl_get(BASE + 32'h10, 10'd43, 32'hDEAD_BEEF);
        tl_get(BASE + 32'hFFC, 10'd44, 32'h1122_3344);
        drain("t6_drain");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
